// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: multi-beat vector integer ALU.
// One VLEN-bit register group is processed as NBEATS beats of BW bits each,
// where BW = 2^NB_LANES * 2^LANE_WIDTH. Results are written into vd one beat
// per cycle. Supported ops: vadd, vsub (carry/borrow is registered between
// beats when SEW > BW), vminu/vmin/vmaxu/vmax (only when SEW <= BW), and
// vand/vor/vxor. Elements with index >= vl keep their vd_old value.
// Optional build macro VEC_ALU_MASK_EN adds the vm/v0 mask ports. With vm=0,
// only elements whose v0 bit is set are written; the others keep vd_old.
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   start               launches an op; only sampled in IDLE
//   opcode, vsew, vl    funct6, element width (8<<vsew), active element count
//   vs1, vs2, vd_old    operands (vd = vs2 op vs1) and prior destination value
//   vm, v0              mask enable (active low) and mask bits (VEC_ALU_MASK_EN only)
//   vd                  result register
//   reg_index           bit offset of the beat being processed
//   busy, done, err     busy while running; done is a 1-cycle pulse; err is valid with done
module vec_alu_pipe #(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned NB_LANES   = 2,
  parameter int unsigned LANE_WIDTH = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [5:0]      opcode,
  input  logic [2:0]      vsew,
  input  logic [9:0]      vl,
  input  logic [VLEN-1:0] vs1,
  input  logic [VLEN-1:0] vs2,
  input  logic [VLEN-1:0] vd_old,
`ifdef VEC_ALU_MASK_EN
  input  logic            vm,
  input  logic [VLEN-1:0] v0,
`endif
  output logic [VLEN-1:0] vd,
  output logic [9:0]      reg_index,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned BW     = (1 << NB_LANES) * (1 << LANE_WIDTH);
  localparam int unsigned NBEATS = VLEN / BW;
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned NCHUNK = BW / 8;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_MINU = 6'b000100;
  localparam logic [5:0] OP_MIN  = 6'b000101;
  localparam logic [5:0] OP_MAXU = 6'b000110;
  localparam logic [5:0] OP_MAX  = 6'b000111;
  localparam logic [5:0] OP_AND  = 6'b001001;
  localparam logic [5:0] OP_OR   = 6'b001010;
  localparam logic [5:0] OP_XOR  = 6'b001011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [5:0]        opcode_q, opcode_d;
  logic [2:0]        vsew_q, vsew_d;
  logic [9:0]        vl_q, vl_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              carry_q, carry_d;
  logic [VLEN-1:0]   vd_q, vd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef VEC_ALU_MASK_EN
  logic              vm_q, vm_d;
  logic [VLEN-1:0]   v0_sh;
`endif

  function automatic logic op_minmax(input logic [5:0] op);
    return (op == OP_MINU) || (op == OP_MIN) || (op == OP_MAXU) || (op == OP_MAX);
  endfunction

  function automatic logic is_illegal(input logic [5:0] op, input logic [2:0] sew,
                                      input logic [9:0] vl_i);
    int unsigned sew_bits;
    logic        known;
    sew_bits = 32'd8 << sew;
    known = (op == OP_ADD) || (op == OP_SUB) || op_minmax(op) ||
            (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
    if (sew > 3'd3)                               return 1'b1;
    if (!known)                                   return 1'b1;
    if (sew_bits > VLEN)                          return 1'b1;
    if (32'(vl_i) > (VLEN >> (32'd3 + 32'(sew)))) return 1'b1;
    if (op_minmax(op) && (sew_bits > BW))         return 1'b1;
    return 1'b0;
  endfunction

  // Operates on the low w bits of a and b; returns {carry_out, result}.
  // Signed compares flip the sign bit so that an unsigned compare can be used.
  function automatic logic [64:0] alu_elem(input logic [5:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input int unsigned w,
                                           input logic cin);
    logic [63:0] mask, sb, bb, res;
    logic [64:0] sum;
    logic        lt_u, lt_s;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sb   = 64'd1 << (w - 1);
    bb   = (op == OP_SUB) ? (~b & mask) : b;
    sum  = {1'b0, a} + {1'b0, bb} + {64'd0, cin};
    lt_u = a < b;
    lt_s = (a ^ sb) < (b ^ sb);
    case (op)
      OP_ADD, OP_SUB: res = sum[63:0] & mask;
      OP_MINU:        res = lt_u ? a : b;
      OP_MIN:         res = lt_s ? a : b;
      OP_MAXU:        res = lt_u ? b : a;
      OP_MAX:         res = lt_s ? b : a;
      OP_AND:         res = a & b;
      OP_OR:          res = a | b;
      OP_XOR:         res = a ^ b;
      default:        res = a;
    endcase
    return {sum[w], res};
  endfunction

  // Beat datapath
  logic [BW-1:0] vs1_beat, vs2_beat, old_beat, res_beat;
  logic          carry_nxt;
  int unsigned   base, sew_bits, chunk_w, off, elem_idx;
  logic [63:0]   cmask, a_c, b_c, old_c, r_c;
  logic [64:0]   alu_r;
  logic          first_c, cin_c, act_c, mask_ok;

  always_comb begin
    base      = 32'(beat_q) * BW;
    sew_bits  = 32'd8 << vsew_q;
    chunk_w   = (sew_bits < BW) ? sew_bits : BW;
    cmask     = (chunk_w >= 64) ? '1 : ((64'd1 << chunk_w) - 64'd1);
    vs1_beat  = vs1[base +: BW];
    vs2_beat  = vs2[base +: BW];
    old_beat  = vd_old[base +: BW];
    res_beat  = '0;
    carry_nxt = 1'b0;
    off       = 0;
    elem_idx  = 0;
    a_c       = '0;
    b_c       = '0;
    old_c     = '0;
    r_c       = '0;
    alu_r     = '0;
    first_c   = 1'b1;
    cin_c     = 1'b0;
    act_c     = 1'b0;
    mask_ok   = 1'b1;
`ifdef VEC_ALU_MASK_EN
    v0_sh     = '0;
`endif
    reg_index = 10'(base);
    // A beat holds BW/chunk_w chunks: whole elements when SEW <= BW, otherwise
    // a single slice of one wide element whose carry chains through carry_q.
    for (int unsigned j = 0; j < NCHUNK; j++) begin
      if (j * chunk_w < BW) begin
        off      = j * chunk_w;
        a_c      = 64'(vs2_beat >> off) & cmask;
        b_c      = 64'(vs1_beat >> off) & cmask;
        old_c    = 64'(old_beat >> off) & cmask;
        elem_idx = (base + off) >> (32'd3 + 32'(vsew_q));
        first_c  = ((base + off) & (sew_bits - 1)) == 0;
        cin_c    = first_c ? (opcode_q == OP_SUB) : carry_q;
        alu_r    = alu_elem(opcode_q, a_c, b_c, chunk_w, cin_c);
`ifdef VEC_ALU_MASK_EN
        v0_sh    = v0 >> elem_idx;
        mask_ok  = vm_q | v0_sh[0];
`endif
        act_c    = (elem_idx < 32'(vl_q)) && mask_ok;
        r_c      = act_c ? alu_r[63:0] : old_c;
        res_beat = res_beat | (BW'(r_c & cmask) << off);
        carry_nxt = alu_r[64];
      end
    end
  end

  // Control FSM
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    vsew_d   = vsew_q;
    vl_d     = vl_q;
    beat_d   = beat_q;
    carry_d  = carry_q;
    vd_d     = vd_q;
`ifdef VEC_ALU_MASK_EN
    vm_d     = vm_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opcode_d = opcode;
          vsew_d   = vsew;
          vl_d     = vl;
`ifdef VEC_ALU_MASK_EN
          vm_d     = vm;
`endif
          beat_d   = '0;
          carry_d  = 1'b0;
          state_d  = is_illegal(opcode, vsew, vl) ? S_ERR : S_RUN;
        end
      end
      S_RUN: begin
        vd_d[base +: BW] = res_beat;
        carry_d = carry_nxt;
        if (beat_q == BEAT_W'(NBEATS - 1)) begin
          beat_d  = '0;
          carry_d = 1'b0;
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_ERR: begin
        vd_d    = vd_old;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Status outputs are registered from the next state so they line up with it.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_DONE) && (state_q == S_ERR);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      vsew_q   <= '0;
      vl_q     <= '0;
      beat_q   <= '0;
      carry_q  <= 1'b0;
      vd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef VEC_ALU_MASK_EN
      vm_q     <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      vsew_q   <= vsew_d;
      vl_q     <= vl_d;
      beat_q   <= beat_d;
      carry_q  <= carry_d;
      vd_q     <= vd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef VEC_ALU_MASK_EN
      vm_q     <= vm_d;
`endif
    end
  end

  assign vd   = vd_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Testbench for vec_alu_pipe (VLEN=128, BW=32, NBEATS=4). Compares outputs
// against an element-level reference model for directed and random operations.
module tb_vec_alu_pipe;
  localparam int VLEN   = 128;
  localparam int BW     = 32;
  localparam int NBEATS = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            start;
  logic [5:0]      opcode;
  logic [2:0]      vsew;
  logic [9:0]      vl;
  logic [VLEN-1:0] vs1, vs2, vd_old, v0;
  logic            vm;
  logic [VLEN-1:0] vd;
  logic [9:0]      reg_index;
  logic            busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  vec_alu_pipe #(.VLEN(128), .NB_LANES(2), .LANE_WIDTH(3)) dut (
    .clk(clk), .resetn(resetn), .start(start), .opcode(opcode), .vsew(vsew), .vl(vl),
    .vs1(vs1), .vs2(vs2), .vd_old(vd_old),
`ifdef VEC_ALU_MASK_EN
    .vm(vm), .v0(v0),
`endif
    .vd(vd), .reg_index(reg_index), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic longint sx(input longint unsigned v, input int s);
    longint t;
    t = longint'(v << (64 - s));
    return t >>> (64 - s);
  endfunction

  function automatic bit ref_illegal(input logic [5:0] op, input logic [2:0] sew, input logic [9:0] vl_i);
    int sewb;
    if (sew > 3) return 1;
    sewb = 8 << sew;
    if (!(op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11})) return 1;
    if (int'(vl_i) > VLEN / sewb) return 1;
    if ((op inside {6'd4, 6'd5, 6'd6, 6'd7}) && sewb > BW) return 1;
    return 0;
  endfunction

  function automatic logic [127:0] ref_vd(input logic [5:0] op, input logic [2:0] sew, input logic [9:0] vl_i,
                                          input logic [127:0] s1, input logic [127:0] s2,
                                          input logic [127:0] old, input logic vm_i, input logic [127:0] v0_i);
    logic [127:0] res, tmp;
    longint unsigned a, b, r, m;
    int sewb;
    if (ref_illegal(op, sew, vl_i)) return old;
    sewb = 8 << sew;
    m = (sewb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sewb) - 1);
    res = old;
    for (int i = 0; i < VLEN / sewb; i++) begin
      if (i < int'(vl_i) && (vm_i || v0_i[i])) begin
        tmp = s2 >> (i * sewb); a = tmp[63:0] & m;
        tmp = s1 >> (i * sewb); b = tmp[63:0] & m;
        case (op)
          6'd0:    r = a + b;
          6'd2:    r = a - b;
          6'd4:    r = (a < b) ? a : b;
          6'd5:    r = (sx(a, sewb) < sx(b, sewb)) ? a : b;
          6'd6:    r = (a > b) ? a : b;
          6'd7:    r = (sx(a, sewb) > sx(b, sewb)) ? a : b;
          6'd9:    r = a & b;
          6'd10:   r = a | b;
          default: r = a ^ b;
        endcase
        r = r & m;
        res = (res & ~({64'd0, m} << (i * sewb))) | ({64'd0, r} << (i * sewb));
      end
    end
    return res;
  endfunction

  task automatic run_op(input string tag, input logic [5:0] op, input logic [2:0] sew, input logic [9:0] vl_i,
                        input logic [127:0] s1, input logic [127:0] s2, input logic [127:0] old,
                        input logic vm_i, input logic [127:0] v0_i, input bit poke_busy, input bit poke_done);
    bit ill, got;
    int n, lat;
    logic [127:0] exp_vd;
    ill    = ref_illegal(op, sew, vl_i);
    exp_vd = ref_vd(op, sew, vl_i, s1, s2, old, vm_i, v0_i);
    lat    = ill ? 2 : NBEATS + 1;
    @(negedge clk);
    opcode = op; vsew = sew; vl = vl_i; vs1 = s1; vs2 = s2; vd_old = old; vm = vm_i; v0 = v0_i;
    start = 1'b1;
    @(posedge clk);
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (!ill && n <= NBEATS) begin
        check_eq({tag, ".reg_index"}, reg_index, 128'((n - 1) * BW));
        check_eq({tag, ".busy"}, busy, 1);
      end
      if (done) got = 1;
      else if (poke_busy && n == 2) begin
        start = 1'b1;
        opcode = 6'b000010;
      end
    end
    check_eq({tag, ".done_seen"}, got, 1);
    check_eq({tag, ".latency"}, n, lat);
    check_eq({tag, ".err"}, err, ill);
    check_eq({tag, ".vd"}, vd, exp_vd);
    if (poke_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, ".done_pulse"}, done, 0);
    check_eq({tag, ".idle_busy"}, busy, 0);
    if (poke_done) begin
      @(negedge clk);
      check_eq({tag, ".no_relaunch"}, busy, 0);
    end
  endtask

  initial begin
    logic [127:0] s1, s2, old;
    logic [5:0] op;
    logic [2:0] sew;
    logic [9:0] vl_r;
    bit saw_done;
    logic [5:0] ops[9] = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11};

    resetn = 1'b0; start = 1'b0; opcode = '0; vsew = '0; vl = '0;
    vs1 = '0; vs2 = '0; vd_old = '0; vm = 1'b1; v0 = '0;
    repeat (2) @(negedge clk);
    check_eq("rst.vd", vd, 0);
    check_eq("rst.reg_index", reg_index, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.err", err, 0);
    resetn = 1'b1;
    @(negedge clk);

    run_op("vand8", 6'b001001, 3'd0, 10'd16, {16{8'hFF}}, {16{8'h0F}}, rnd128(), 1'b1, '0, 0, 0);
    check_eq("vand8.const", vd, {16{8'h0F}});

    s2 = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    s1 = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001};
    run_op("vadd64", 6'b000000, 3'd3, 10'd2, s1, s2, rnd128(), 1'b1, '0, 0, 0);
    check_eq("vadd64.const", vd, {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_0000_0000});

    run_op("vsub16", 6'b000010, 3'd1, 10'd8, {8{16'h0001}}, '0, rnd128(), 1'b1, '0, 0, 0);
    check_eq("vsub16.const", vd, {8{16'hFFFF}});

    run_op("vmin8", 6'b000101, 3'd0, 10'd16, {16{8'h01}}, {16{8'hFF}}, rnd128(), 1'b1, '0, 0, 0);
    check_eq("vmin8.const", vd, {16{8'hFF}});
    run_op("vminu8", 6'b000100, 3'd0, 10'd16, {16{8'h01}}, {16{8'hFF}}, rnd128(), 1'b1, '0, 0, 0);
    check_eq("vminu8.const", vd, {16{8'h01}});

    s1 = rnd128(); s2 = rnd128(); old = {16{8'hA5}};
    run_op("vor32", 6'b001010, 3'd2, 10'd3, s1, s2, old, 1'b1, '0, 0, 0);
    check_eq("vor32.tail", vd[127:96], 32'hA5A5_A5A5);
    check_eq("vor32.body", vd[95:0], (s1[95:0] | s2[95:0]));
    old = rnd128();
    run_op("vl0", 6'b001010, 3'd2, 10'd0, rnd128(), rnd128(), old, 1'b1, '0, 0, 0);
    check_eq("vl0.const", vd, old);

    old = rnd128();
    run_op("vmax64", 6'b000111, 3'd3, 10'd2, rnd128(), rnd128(), old, 1'b1, '0, 0, 1);
    check_eq("vmax64.old", vd, old);
    run_op("sew4", 6'b000000, 3'd4, 10'd1, rnd128(), rnd128(), rnd128(), 1'b1, '0, 0, 0);
    run_op("vl_big", 6'b000000, 3'd0, 10'd17, rnd128(), rnd128(), rnd128(), 1'b1, '0, 0, 0);
    run_op("bad_op", 6'b111111, 3'd0, 10'd4, rnd128(), rnd128(), rnd128(), 1'b1, '0, 0, 0);
    run_op("busy_start", 6'b000000, 3'd0, 10'd16, rnd128(), rnd128(), rnd128(), 1'b1, '0, 1, 0);
    run_op("vsub64", 6'b000010, 3'd3, 10'd2, rnd128(), rnd128(), rnd128(), 1'b1, '0, 0, 1);

    for (int k = 0; k < 60; k++) begin
      op  = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(12, 63)) : ops[$urandom_range(0, 8)];
      sew = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      vl_r = (sew > 3) ? 10'd1 : 10'($urandom_range(0, (VLEN >> (3 + sew)) + 1));
      run_op("rand", op, sew, vl_r, rnd128(), rnd128(), rnd128(), 1'b1, '0, 0, 0);
    end

    // Asynchronous reset in the middle of beat 2
    @(negedge clk);
    opcode = 6'b000000; vsew = 3'd0; vl = 10'd16;
    vs1 = {16{8'h11}}; vs2 = {16{8'h22}}; vd_old = '0; vm = 1'b1;
    start = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk) start = 1'b0;
    check_eq("rstmid.reg_index_pre", reg_index, 64);
    resetn = 1'b0;
    #1;
    check_eq("rstmid.vd", vd, 0);
    check_eq("rstmid.reg_index", reg_index, 0);
    check_eq("rstmid.busy", busy, 0);
    check_eq("rstmid.done", done, 0);
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (i == 1) resetn = 1'b1;
    end
    check_eq("rstmid.no_done", saw_done, 0);
    run_op("after_rst", 6'b001011, 3'd1, 10'd8, rnd128(), rnd128(), rnd128(), 1'b1, '0, 0, 0);

`ifdef VEC_ALU_MASK_EN
    old = rnd128();
    run_op("mask8", 6'b000000, 3'd0, 10'd16, rnd128(), rnd128(), old, 1'b0, 128'h00FF, 0, 0);
    check_eq("mask8.undisturbed", vd[127:64], old[127:64]);
    for (int k = 0; k < 10; k++)
      run_op("mask_rand", ops[$urandom_range(0, 8)], 3'($urandom_range(0, 2)), 10'($urandom_range(0, 4)),
             rnd128(), rnd128(), rnd128(), 1'($urandom_range(0, 1)), rnd128(), 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
